// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encodings, baud divider helper and parameter limits
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  localparam int MIN_DIV        = 2;
  localparam int MIN_OVERSAMPLE = 8;
  localparam int MIN_DATA_BITS  = 5;
  localparam int MAX_DATA_BITS  = 9;

  // Rounded clock divider producing one oversample tick
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int den;
    den = baud * oversample;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running mod-DIV counter emitting a 1-cycle oversample tick
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic os_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < MIN_DIV) begin : g_bad_div
    $error("uart_baud_gen: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    os_tick = (cnt_q == CW'(DIV - 1));
    cnt_d   = os_tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - full-duplex UART transceiver with valid/ready byte ports
// Define UART_PARITY_EN to add a parity bit (even/odd per PARITY_ODD) to every frame.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 txclk,
  output logic                 rxclk
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  if (OVERSAMPLE < MIN_OVERSAMPLE || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_xcvr: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_db
    $error("uart_xcvr: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_xcvr: STOP_BITS must be 1 or 2");
  end

  logic os_tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .os_tick (os_tick)
  );

  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [OS_W-1:0]      tx_os_q, tx_os_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 txd_q, txd_d;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_bit_end = (tx_state_q != ST_IDLE) && os_tick && (tx_os_q == OS_LAST);
    if (tx_state_q == ST_IDLE) begin
      if (tx_valid) begin
        tx_state_d = ST_START;
        tx_shift_d = tx_data;
        tx_os_d    = '0;
        tx_bit_d   = '0;
        txd_d      = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
      end
    end else if (os_tick) begin
      tx_os_d = tx_os_q + OS_W'(1);
      if (tx_bit_end) begin
        tx_os_d = '0;
        case (tx_state_q)
          ST_START: begin
            tx_state_d = ST_DATA;
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
          ST_DATA: begin
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_d   = '0;
`ifdef UART_PARITY_EN
              tx_state_d = ST_PARITY;
              txd_d      = tx_par_q;
`else
              tx_state_d = ST_STOP;
              txd_d      = 1'b1;
`endif
            end else begin
              tx_bit_d   = tx_bit_q + 4'd1;
              txd_d      = tx_shift_q[0];
              tx_shift_d = tx_shift_q >> 1;
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end
`endif
          ST_STOP: begin
            txd_d = 1'b1;
            if (tx_bit_q == STOP_LAST) tx_state_d = ST_IDLE;
            else                       tx_bit_d   = tx_bit_q + 4'd1;
          end
          default: begin
            tx_state_d = ST_IDLE;
            txd_d      = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_shift_q <= '0;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // Synchroniser flops reset to the idle-high line level
  logic                 rxd_meta_q, rxd_sync_q;
  uart_state_e          rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [OS_W-1:0]      rx_os_q, rx_os_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_sample;
`ifdef UART_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 par_err_q, par_err_d;
`endif

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_os_d     = rx_os_q;
    rx_bit_d    = rx_bit_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    rx_sample = os_tick &&
                (((rx_state_q == ST_START) && (rx_os_q == OS_HALF)) ||
                 (((rx_state_q == ST_DATA) || (rx_state_q == ST_PARITY) ||
                   (rx_state_q == ST_STOP)) && (rx_os_q == OS_LAST)));
    if (os_tick && rx_state_q != ST_IDLE && rx_state_q != ST_BREAK)
      rx_os_d = rx_sample ? '0 : rx_os_q + OS_W'(1);
    case (rx_state_q)
      ST_IDLE: begin
        if (!rxd_sync_q) begin
          rx_state_d = ST_START;
          rx_os_d    = '0;
        end
      end
      ST_START: begin
        if (rx_sample) begin
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (rx_sample) begin
          par_bad_d  = rxd_sync_q ^ (^rx_shift_q) ^ 1'(PARITY_ODD);
          rx_state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (rx_sample) begin
          rx_state_d = ST_IDLE;
          if (!rxd_sync_q) begin
            frame_err_d = 1'b1;
            rx_state_d  = ST_BREAK;
          end else if (rx_valid_q && !rx_ready) begin
            overrun_d = 1'b1;
          end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
`ifdef UART_PARITY_EN
            par_err_d  = par_bad_q;
`endif
          end
        end
      end
      ST_BREAK: begin
        if (rxd_sync_q) rx_state_d = ST_IDLE;
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_os_q     <= '0;
      rx_bit_q    <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= rxd;
      rxd_sync_q  <= rxd_meta_q;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_os_q     <= rx_os_d;
      rx_bit_q    <= rx_bit_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign tx_ready     = (tx_state_q == ST_IDLE);
  assign txd          = txd_q;
  assign txclk        = tx_bit_end;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
  assign rxclk        = rx_sample;
`ifdef UART_PARITY_EN
  assign rx_parity_err = par_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - directed self-checking bench for uart_xcvr (160 clk per bit)
module tb_uart_xcvr;

`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB = 10 + PB;

  logic       clk = 1'b0;
  logic       rst, tx_valid, rx_ready, loop_en, rxd_force, par_flip;
  logic [7:0] tx_data;
  logic       tx_ready, txd, rxd, rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err, rx_parity_err, rx_overrun, txclk, rxclk;

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, txclk_cnt = 0, rx_rise_cnt = 0;
  int rx_rise_cyc = 0, txr_rise_cyc = 0;
  logic rx_valid_prev = 1'b0, tx_ready_prev = 1'b0;

  assign rxd = loop_en ? txd : rxd_force;

  uart_xcvr #(
    .CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun),
    .txclk(txclk), .rxclk(rxclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (rx_frame_err) fe_cnt++;
    if (rx_parity_err) pe_cnt++;
    if (rx_overrun) ov_cnt++;
    if (txclk) txclk_cnt++;
    if (rx_valid && !rx_valid_prev) begin rx_rise_cnt++; rx_rise_cyc = cyc; end
    if (tx_ready && !tx_ready_prev) txr_rise_cyc = cyc;
    rx_valid_prev = rx_valid;
    tx_ready_prev = tx_ready;
  end

  task automatic rx_accept();
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_serial(input logic [7:0] d, input logic stop_v);
    rxd_force = 1'b0; repeat (160) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd_force = d[i]; repeat (160) @(negedge clk); end
`ifdef UART_PARITY_EN
    rxd_force = (^d) ^ par_flip; repeat (160) @(negedge clk);
`endif
    rxd_force = stop_v; repeat (160) @(negedge clk);
    rxd_force = 1'b1; repeat (20) @(negedge clk);
  endtask

  task automatic tx_frame(input logic [7:0] d, output int slen, output logic [15:0] bits);
    int t;
    bits = '0; slen = 0; t = 0;
    @(negedge clk); tx_data = d; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0; acc_cyc = cyc;
    while (txd === 1'b0 && slen < 400) begin slen++; @(negedge clk); end
    repeat (80) @(negedge clk);
    for (int i = 0; i < FB - 1; i++) begin
      bits[i] = txd;
      if (i < FB - 2) repeat (160) @(negedge clk);
    end
    while (tx_ready !== 1'b1 && t < 400) begin t++; @(negedge clk); end
    total++; if (t >= 400) begin bad++; $display("FAIL tx_ready_timeout: waited %0d cycles, limit 400", t); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0; loop_en = 1'b0; rxd_force = 1'b1;
    par_flip = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++;
    if ({rx_frame_err, rx_parity_err, rx_overrun, txclk, rxclk} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 00000",
                      {rx_frame_err, rx_parity_err, rx_overrun, txclk, rxclk});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_loopback();
    int slen, rx0, tc0;
    logic [15:0] bits;
    loop_en = 1'b1; rx0 = rx_rise_cnt; tc0 = txclk_cnt;
    tx_frame(8'hA5, slen, bits);
    total++; if (slen < 151 || slen > 160) begin bad++; $display("FAIL lb_start_len: got %0d want 151..160", slen); end
    total++; if (bits[7:0] !== 8'hA5) begin bad++; $display("FAIL lb_tx_bits: got %h want a5", bits[7:0]); end
    total++; if (bits[FB-2] !== 1'b1) begin bad++; $display("FAIL lb_stop_bit: got %b want 1", bits[FB-2]); end
    total++; if (rx_rise_cnt - rx0 !== 1) begin bad++; $display("FAIL lb_rx_count: got %0d want 1", rx_rise_cnt - rx0); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL lb_rx_data: got %h want a5", rx_data); end
    total++;
    if (rx_rise_cyc - acc_cyc < 160 * (FB - 1) + 70 || rx_rise_cyc - acc_cyc > 160 * (FB - 1) + 90) begin
      bad++; $display("FAIL lb_rx_latency: got %0d want %0d..%0d", rx_rise_cyc - acc_cyc,
                      160 * (FB - 1) + 70, 160 * (FB - 1) + 90);
    end
    total++;
    if (txr_rise_cyc - acc_cyc < 160 * FB - 9 || txr_rise_cyc - acc_cyc > 160 * FB + 1) begin
      bad++; $display("FAIL lb_tx_ready_latency: got %0d want %0d..%0d", txr_rise_cyc - acc_cyc,
                      160 * FB - 9, 160 * FB + 1);
    end
    total++; if (txclk_cnt - tc0 !== FB) begin bad++; $display("FAIL lb_txclk_count: got %0d want %0d", txclk_cnt - tc0, FB); end
    rx_accept();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL lb_rx_accept: got %b want 0", rx_valid); end
    loop_en = 1'b0;
  endtask

  task automatic test_glitch();
    int rx0, err0;
    rx0 = rx_rise_cnt; err0 = fe_cnt + pe_cnt + ov_cnt;
    rxd_force = 1'b0; repeat (40) @(negedge clk);
    rxd_force = 1'b1; repeat (300) @(negedge clk);
    total++; if (rx_rise_cnt - rx0 !== 0) begin bad++; $display("FAIL glitch_no_valid: got %0d want 0", rx_rise_cnt - rx0); end
    total++; if (fe_cnt + pe_cnt + ov_cnt - err0 !== 0) begin bad++; $display("FAIL glitch_no_flags: got %0d want 0", fe_cnt + pe_cnt + ov_cnt - err0); end
    send_serial(8'h3C, 1'b1);
    total++; if (rx_rise_cnt - rx0 !== 1) begin bad++; $display("FAIL glitch_next_count: got %0d want 1", rx_rise_cnt - rx0); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL glitch_next_data: got %h want 3c", rx_data); end
    rx_accept();
  endtask

  task automatic test_frame_err();
    int rx0, fe0;
    rx0 = rx_rise_cnt; fe0 = fe_cnt;
    send_serial(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL frame_err_pulse: got %0d cycles want 1", fe_cnt - fe0); end
    total++; if (rx_rise_cnt - rx0 !== 0) begin bad++; $display("FAIL frame_err_no_valid: got %0d want 0", rx_rise_cnt - rx0); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL frame_err_rx_valid: got %b want 0", rx_valid); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt; rx_ready = 1'b0;
    send_serial(8'h11, 1'b1);
    send_serial(8'h22, 1'b1);
    total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL overrun_pulse: got %0d cycles want 1", ov_cnt - ov0); end
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL overrun_keep_data: got %h want 11", rx_data); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid: got %b want 1", rx_valid); end
    rx_accept();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL overrun_accept: got %b want 0", rx_valid); end
  endtask

  task automatic test_tx_reset();
    loop_en = 1'b0; rxd_force = 1'b1;
    @(negedge clk); tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    repeat (880) @(negedge clk);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL txrst_bit4_level: got %b want 0", txd); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL txrst_busy: got %b want 0", tx_ready); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL txrst_txd: got %b want 1", txd); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL txrst_tx_ready: got %b want 1", tx_ready); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_parity();
`ifdef UART_PARITY_EN
    int slen, pe0;
    logic [15:0] bits;
    loop_en = 1'b1; pe0 = pe_cnt;
    tx_frame(8'hA5, slen, bits);
    total++; if (bits[8] !== 1'b0) begin bad++; $display("FAIL par_tx_bit: got %b want 0", bits[8]); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL par_good_data: got %h want a5", rx_data); end
    total++; if (pe_cnt - pe0 !== 0) begin bad++; $display("FAIL par_good_flag: got %0d want 0", pe_cnt - pe0); end
    rx_accept();
    loop_en = 1'b0; par_flip = 1'b1;
    send_serial(8'hA5, 1'b1);
    par_flip = 1'b0;
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_err_pulse: got %0d cycles want 1", pe_cnt - pe0); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL par_err_data: got %h want a5", rx_data); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL par_err_valid: got %b want 1", rx_valid); end
    rx_accept();
`else
    total++; if (pe_cnt !== 0) begin bad++; $display("FAIL par_tied_low: got %0d cycles want 0", pe_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_tx_reset();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
